pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'd0, as the PC value loaded on reset.
REQ-002 The block SHALL take parameter FETCH_TIMEOUT, default 15, as the maximum FETCH wait in cycles before error; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: begin sequencing from IDLE.
REQ-006 The block SHALL have port imem_valid, input, 1 bit: instruction memory has returned the word at pc.
REQ-007 The block SHALL have port exec_done, input, 1 bit: the datapath has finished executing the current instruction.
REQ-008 The block SHALL have port branch_taken, input, 1 bit: the current instruction redirects the PC.
REQ-009 The block SHALL have port branch_target, input, 32 bits: the redirect address.
REQ-010 The block SHALL have port halt_req, input, 1 bit: the current instruction is a halt.
REQ-011 The block SHALL have port stall, input, 1 bit: hold the PC update.
REQ-012 The block SHALL have port pc, output, 32 bits: the current program counter (word address).
REQ-013 The block SHALL have port imem_rd, output, 1 bit: instruction fetch request.
REQ-014 The block SHALL have port exec_en, output, 1 bit: datapath execute enable.
REQ-015 The block SHALL have port busy, output, 1 bit: high in FETCH, EXEC and UPDATE.
REQ-016 The block SHALL have port halted, output, 1 bit: high in HALT.
REQ-017 The block SHALL have port err, output, 1 bit: sticky fetch-timeout flag.
REQ-018 The block SHALL have port instr_count, output, 32 bits: count of retired instructions.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, EXEC, UPDATE and HALT; all outputs SHALL be registered or decoded from state only.
- IDLE -> FETCH when start=1.
- FETCH: imem_rd=1; -> EXEC on imem_valid=1; -> HALT with err set when the wait counter reaches FETCH_TIMEOUT cycles without imem_valid.
- EXEC: exec_en=1; on exec_done=1, latch branch_taken, branch_target and halt_req, then -> UPDATE.
- UPDATE: if stall=1, remain in UPDATE with pc unchanged; otherwise commit.
REQ-020 A commit SHALL select the next PC with priority halt > branch > sequential:
- halt: pc unchanged, -> HALT.
- branch: pc = latched target, -> FETCH.
- sequential: pc = pc+1, -> FETCH.
REQ-021 pc+1 SHALL be a 32-bit add that wraps 32'hFFFFFFFF to 32'h00000000 with no flag.
REQ-022 instr_count SHALL increment by 1 on every commit, halt included, and SHALL wrap modulo 2^32.
REQ-023 The minimum instruction period SHALL be 3 cycles (FETCH, EXEC, UPDATE) when imem_valid and exec_done arrive in their first cycle.
REQ-024 The block SHALL ignore start outside IDLE, imem_valid outside FETCH, and exec_done, branch_taken, branch_target and halt_req outside EXEC.
REQ-025 stall SHALL take effect only in UPDATE; branch and halt values latched in EXEC SHALL persist across stall cycles.
REQ-026 HALT SHALL be absorbing; only rst leaves it.
REQ-027 The FETCH wait counter SHALL clear on every entry to FETCH.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL enter IDLE from any state, including mid-FETCH and mid-stall, with pc=RESET_PC, instr_count=0, err=0, imem_rd=0, exec_en=0, busy=0, halted=0, and the latched branch/halt values and wait counter cleared.
REQ-029 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-030 The bench SHALL cover sequential flow: start; imem_valid and exec_done immediate, three times -> pc 0,1,2,3 at each FETCH entry, instr_count=3, 3 cycles per instruction.
REQ-031 The bench SHALL cover a taken branch: branch_taken=1 with branch_target=32'h40 at exec_done -> next FETCH pc=32'h40; a stall of 2 cycles in UPDATE -> commit delayed by exactly 2 cycles, target still 32'h40.
REQ-032 The bench SHALL cover wrap: RESET_PC=32'hFFFFFFFF, one sequential commit -> pc=32'h00000000.
REQ-033 The bench SHALL cover halt priority: halt_req=1 and branch_taken=1 together -> HALT, pc unchanged, halted=1, instr_count incremented, later start ignored.
REQ-034 The bench SHALL cover fetch timeout: imem_valid held low for FETCH_TIMEOUT=15 cycles -> HALT with err=1; then rst=1 -> IDLE, err=0, pc=RESET_PC.
REQ-035 The bench SHALL cover reset mid-operation: rst asserted in EXEC -> the next cycle shows IDLE outputs with exec_en=0 and instr_count=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps FETCH -> EXEC -> UPDATE per instruction, handles
// branch/halt redirects, stall in UPDATE, and a bounded wait for instruction memory.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'd0,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        imem_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    input  logic        stall,
    output logic [31:0] pc,
    output logic        imem_rd,
    output logic        exec_en,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StUpdate,
        StHalt
    } state_e;

    // Last FETCH wait cycle that may still accept imem_valid before timing out.
    localparam logic [7:0] TimeoutLast = 8'(FETCH_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [7:0]  wait_q, wait_d;
    logic        br_taken_q, br_taken_d;
    logic [31:0] br_target_q, br_target_d;
    logic        halt_q, halt_d;
    logic        imem_rd_q, imem_rd_d;
    logic        exec_en_q, exec_en_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        wait_d      = wait_q;
        br_taken_d  = br_taken_q;
        br_target_d = br_target_q;
        halt_d      = halt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    wait_d  = 8'd0;
                end
            end
            StFetch: begin
                if (imem_valid) begin
                    state_d = StExec;
                end else if (wait_q == TimeoutLast) begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StExec: begin
                if (exec_done) begin
                    br_taken_d  = branch_taken;
                    br_target_d = branch_target;
                    halt_d      = halt_req;
                    state_d     = StUpdate;
                end
            end
            StUpdate: begin
                if (!stall) begin
                    cnt_d = cnt_q + 32'd1;
                    if (halt_q) begin
                        state_d = StHalt;
                    end else begin
                        state_d = StFetch;
                        wait_d  = 8'd0;
                        pc_d    = br_taken_q ? br_target_q : pc_q + 32'd1;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Output flags follow the next state so they are registered alongside it.
        imem_rd_d = (state_d == StFetch);
        exec_en_d = (state_d == StExec);
        busy_d    = (state_d == StFetch) || (state_d == StExec) || (state_d == StUpdate);
        halted_d  = (state_d == StHalt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            cnt_q       <= 32'd0;
            err_q       <= 1'b0;
            wait_q      <= 8'd0;
            br_taken_q  <= 1'b0;
            br_target_q <= 32'd0;
            halt_q      <= 1'b0;
            imem_rd_q   <= 1'b0;
            exec_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            halt_q      <= halt_d;
            imem_rd_q   <= imem_rd_d;
            exec_en_q   <= exec_en_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    assign pc          = pc_q;
    assign instr_count = cnt_q;
    assign err         = err_q;
    assign imem_rd     = imem_rd_q;
    assign exec_en     = exec_en_q;
    assign busy        = busy_q;
    assign halted      = halted_q;

endmodule
